reg_arbiter: RTL and testbench

REG_ARBITER -- requirements
Module: reg_arbiter

---
 rtl/reg_arb_pkg.sv | 26 ++
 rtl/reg_arbiter_rr_picker.sv | 37 +++
 rtl/reg_arbiter.sv | 166 ++++++++++++++++
 tb/tb_reg_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// -----------------------------------------------------------------------------
// reg_arb_pkg
// Shared definitions for the register-write arbiter slice.
//   state_t        : four-state transaction FSM encoding (IDLE, GRANT, WRITE, ACK)
//   DEFAULT_WIDTH  : default data width of the shared register
//   DEFAULT_N_REQ  : default number of requesters
//   next_index()   : modular increment used for the round-robin pointer
// -----------------------------------------------------------------------------
package reg_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      WRITE = 2'd2,
      ACK   = 2'd3
   } state_t;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_N_REQ = 4;

   // Index that follows idx in a ring of n requesters.
   function automatic int next_index(input int idx, input int n);
      return (idx + 1) % n;
   endfunction

endpackage

// File: rtl/reg_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector. Searches req starting at ptr and moving
// upward, wrapping from N_REQ-1 back to 0, and reports the first set bit.
//   req    : in  N_REQ  request vector
//   ptr    : in  IDX_W  search start position
//   winner : out IDX_W  index of the selected requester (0 when none)
//   valid  : out 1      high when any request bit is set
// -----------------------------------------------------------------------------
module rr_picker #(
   parameter int N_REQ = 4,
   parameter int IDX_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] winner,
   output logic             valid
);

   int idx;

   // Walk the ring from the farthest offset back to ptr itself so that the
   // closest set bit to ptr is the last assignment and therefore wins.
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      idx    = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % N_REQ;
         if (req[idx]) begin
            winner = IDX_W'(idx);
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/reg_arbiter.sv
// -----------------------------------------------------------------------------
// reg_arbiter
// Arbitrates N_REQ requesters for write access to one shared external
// register. Each transaction runs IDLE -> GRANT -> WRITE -> ACK -> IDLE:
// the winner and its data are latched on leaving IDLE, the register is
// written in WRITE, and the winner receives a one-cycle ack in ACK while the
// register's Q output is captured into rdata.
//
// Optional feature: define REG_ARB_READBACK_EN to compare reg_q against the
// written data in ACK and raise the sticky err flag on a mismatch. Without
// the macro err is constant 0 and no compare logic exists.
//
// Ports:
//   clk    : in  1            clock, rising edge
//   reset  : in  1            synchronous active-high reset
//   req    : in  N_REQ        per-requester write request
//   wdata  : in  N_REQ*WIDTH  per-requester write data, slice i*WIDTH
//   ack    : out N_REQ        one-cycle completion pulse to the winner
//   reg_d  : out WIDTH        D input of the shared register
//   reg_en : out 1            enable of the shared register
//   reg_q  : in  WIDTH        Q output of the shared register
//   rdata  : out WIDTH        reg_q captured in the ACK cycle
//   busy   : out 1            high whenever not IDLE
//   err    : out 1            sticky readback-mismatch flag
// -----------------------------------------------------------------------------
module reg_arbiter
   import reg_arb_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int N_REQ = DEFAULT_N_REQ
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] wdata,
   output logic [N_REQ-1:0]       ack,
   output logic [WIDTH-1:0]       reg_d,
   output logic                   reg_en,
   input  logic [WIDTH-1:0]       reg_q,
   output logic [WIDTH-1:0]       rdata,
   output logic                   busy,
   output logic                   err
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   state_t             state_q,  state_d;
   logic [IDX_W-1:0]   ptr_q,    ptr_d;
   logic [IDX_W-1:0]   winner_q, winner_d;
   logic [WIDTH-1:0]   data_q,   data_d;
   logic               reg_en_q, reg_en_d;
   logic [WIDTH-1:0]   reg_d_q,  reg_d_d;
   logic [N_REQ-1:0]   ack_q,    ack_d;
   logic [WIDTH-1:0]   rdata_q,  rdata_d;

   logic [IDX_W-1:0]   pick_idx;
   logic               pick_valid;

`ifdef REG_ARB_READBACK_EN
   logic               err_q, err_d;
   logic               mismatch;
`endif

   rr_picker #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_picker (
      .req    (req),
      .ptr    (ptr_q),
      .winner (pick_idx),
      .valid  (pick_valid)
   );

`ifdef REG_ARB_READBACK_EN
   // The register was written at the end of WRITE, so reg_q reflects the new
   // value during ACK and only then is a comparison meaningful.
   assign mismatch = (state_q == ACK) && (reg_q != data_q);
`endif

   // Next-state and next-output logic. Outputs are precomputed here so that
   // reg_en and ack are flop outputs aligned with the WRITE and ACK states.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      winner_d = winner_q;
      data_d   = data_q;
      reg_en_d = 1'b0;
      reg_d_d  = reg_d_q;
      ack_d    = '0;
      rdata_d  = rdata_q;
`ifdef REG_ARB_READBACK_EN
      err_d    = err_q | mismatch;
`endif
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d  = GRANT;
               winner_d = pick_idx;
               data_d   = wdata[pick_idx*WIDTH +: WIDTH];
            end
         end
         GRANT: begin
            state_d  = WRITE;
            reg_en_d = 1'b1;
            reg_d_d  = data_q;
         end
         WRITE: begin
            state_d          = ACK;
            ack_d[winner_q]  = 1'b1;
         end
         ACK: begin
            state_d = IDLE;
            rdata_d = reg_q;
            ptr_d   = IDX_W'(next_index(int'(winner_q), N_REQ));
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Single state register for the FSM and all registered outputs; reset
   // abandons any transaction in flight without issuing its ack.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         winner_q <= '0;
         data_q   <= '0;
         reg_en_q <= 1'b0;
         reg_d_q  <= '0;
         ack_q    <= '0;
         rdata_q  <= '0;
`ifdef REG_ARB_READBACK_EN
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         winner_q <= winner_d;
         data_q   <= data_d;
         reg_en_q <= reg_en_d;
         reg_d_q  <= reg_d_d;
         ack_q    <= ack_d;
         rdata_q  <= rdata_d;
`ifdef REG_ARB_READBACK_EN
         err_q    <= err_d;
`endif
      end
   end

   assign ack    = ack_q;
   assign reg_en = reg_en_q;
   assign reg_d  = reg_d_q;
   assign rdata  = rdata_q;
   assign busy   = (state_q != IDLE);

`ifdef REG_ARB_READBACK_EN
   // The mismatch term makes err visible already in the ACK cycle itself;
   // err_q keeps it set afterwards.
   assign err = err_q | mismatch;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_reg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_arbiter
// Self-checking bench for reg_arbiter (WIDTH=8, N_REQ=4). Models the shared
// register, drives directed table vectors, hand-written corner sequences and
// randomized transactions, and compares against a behavioural model of the
// round-robin arbitration rules.
// -----------------------------------------------------------------------------
module tb_reg_arbiter;

   localparam int W = 8;
   localparam int N = 4;
`ifdef REG_ARB_READBACK_EN
   localparam bit READBACK = 1'b1;
`else
   localparam bit READBACK = 1'b0;
`endif

   logic             clk;
   logic             reset;
   logic [N-1:0]     req;
   logic [N*W-1:0]   wdata;
   logic [N-1:0]     ack;
   logic [W-1:0]     reg_d;
   logic             reg_en;
   logic [W-1:0]     reg_q;
   logic [W-1:0]     rdata;
   logic             busy;
   logic             err;

   logic [W-1:0]     shadowReg;
   bit               forceZero;

   int               checks;
   int               errors;
   int               cycleCount;
   int               lastAckCycle;
   int               modelPtr;
   bit               errModel;

   typedef struct {
      logic [N-1:0]   req;
      logic [N*W-1:0] wdata;
      int             expWinner;
   } vec_t;

   vec_t vecs[6];

   reg_arbiter #(
      .WIDTH (W),
      .N_REQ (N)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .req    (req),
      .wdata  (wdata),
      .ack    (ack),
      .reg_d  (reg_d),
      .reg_en (reg_en),
      .reg_q  (reg_q),
      .rdata  (rdata),
      .busy   (busy),
      .err    (err)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // The shared register the arbiter writes into; forceZero models a
   // register that fails to hold the written value.
   always @(posedge clk) begin
      if (reg_en) shadowReg <= reg_d;
      cycleCount <= cycleCount + 1;
   end

   assign reg_q = forceZero ? '0 : shadowReg;

   // Safety net in case the run stalls
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [N-1:0] r, input logic [N*W-1:0] wd);
      req   = r;
      wdata = wd;
   endtask

   // Reference rule: first set request found by walking the ring from ptr.
   function automatic int modelPick(input logic [N-1:0] r, input int p);
      int order[$];
      for (int k = 0; k < N; k++) order.push_back((p + k) % N);
      foreach (order[i]) if (r[order[i]]) return order[i];
      return -1;
   endfunction

   task automatic doReset();
      reset = 1'b1;
      applyStimulus('0, '0);
      step();
      step();
      checkOutput("rst ack", 32'(ack), 0);
      checkOutput("rst reg_en", 32'(reg_en), 0);
      checkOutput("rst reg_d", 32'(reg_d), 0);
      checkOutput("rst rdata", 32'(rdata), 0);
      checkOutput("rst busy", 32'(busy), 0);
      checkOutput("rst err", 32'(err), 0);
      reset    = 1'b0;
      modelPtr = 0;
      errModel = 1'b0;
   endtask

   // One full transaction starting from an IDLE cycle; returns positioned at
   // the first IDLE cycle afterwards.
   task automatic runTxn(input logic [N-1:0] r, input logic [N*W-1:0] wd,
                         input int expW, input bit drop, input string tag);
      logic [W-1:0] expData;
      logic [N-1:0] expAck;
      expData = wd[expW*W +: W];
      expAck  = N'(1) << expW;
      applyStimulus(r, wd);
      checkOutput({tag, " c0 busy"}, 32'(busy), 0);
      step();
      checkOutput({tag, " c1 busy"}, 32'(busy), 1);
      checkOutput({tag, " c1 reg_en"}, 32'(reg_en), 0);
      checkOutput({tag, " c1 ack"}, 32'(ack), 0);
      // Data and request changes after grant must not affect the transaction.
      wdata = {$urandom};
      if (drop) req = r & ~expAck;
      step();
      checkOutput({tag, " c2 reg_en"}, 32'(reg_en), 1);
      checkOutput({tag, " c2 reg_d"}, 32'(reg_d), 32'(expData));
      checkOutput({tag, " c2 ack"}, 32'(ack), 0);
      checkOutput({tag, " c2 err"}, 32'(err), 32'(errModel));
      step();
      if (READBACK && forceZero && expData != '0) errModel = 1'b1;
      checkOutput({tag, " c3 ack"}, 32'(ack), 32'(expAck));
      checkOutput({tag, " c3 reg_en"}, 32'(reg_en), 0);
      checkOutput({tag, " c3 reg_d"}, 32'(reg_d), 32'(expData));
      checkOutput({tag, " c3 busy"}, 32'(busy), 1);
      checkOutput({tag, " c3 err"}, 32'(err), 32'(errModel));
      lastAckCycle = cycleCount;
      step();
      checkOutput({tag, " c4 rdata"}, 32'(rdata), forceZero ? 0 : 32'(expData));
      checkOutput({tag, " c4 ack"}, 32'(ack), 0);
      checkOutput({tag, " c4 busy"}, 32'(busy), 0);
      checkOutput({tag, " c4 err"}, 32'(err), 32'(errModel));
      modelPtr = (expW + 1) % N;
   endtask

   task automatic runIdle(input string tag);
      applyStimulus('0, {$urandom});
      checkOutput({tag, " idle busy"}, 32'(busy), 0);
      checkOutput({tag, " idle ack"}, 32'(ack), 0);
      checkOutput({tag, " idle reg_en"}, 32'(reg_en), 0);
      step();
   endtask

   initial begin
      logic [N-1:0]   r;
      logic [N*W-1:0] wd;
      int             w;
      int             prevAck;

      checks     = 0;
      errors     = 0;
      cycleCount = 0;
      forceZero  = 1'b0;
      shadowReg  = '0;
      reset      = 1'b1;
      applyStimulus('0, '0);

      // Directed table from reset (ptr starts at 0)
      vecs[0] = '{req: 4'b0100, wdata: 32'h00A5_0000, expWinner: 2};
      vecs[1] = '{req: 4'b1001, wdata: 32'h3300_0011, expWinner: 3};
      vecs[2] = '{req: 4'b1001, wdata: 32'h3300_0011, expWinner: 0};
      vecs[3] = '{req: 4'b0001, wdata: 32'h0000_0077, expWinner: 0};
      vecs[4] = '{req: 4'b1100, wdata: 32'hC3D4_0000, expWinner: 2};
      vecs[5] = '{req: 4'b0110, wdata: 32'h00BE_EF00, expWinner: 1};

      doReset();
      for (int i = 0; i < 6; i++) runTxn(vecs[i].req, vecs[i].wdata, vecs[i].expWinner, 1'b0, "table");

      // Early drop: ptr is 2, requester 1 drops req during GRANT
      runTxn(4'b0010, 32'h0000_5A00, 1, 1'b1, "drop");
      runIdle("drop after");
      // ptr must now be 2, so requester 2 beats requester 1
      runTxn(4'b0110, 32'h0066_1100, 2, 1'b0, "drop ptr");

      // Round robin with all requests held
      doReset();
      prevAck = 0;
      for (int k = 0; k < 5; k++) begin
         runTxn(4'b1111, 32'h4433_2211, k % N, 1'b0, "rr");
         if (k > 0) checkOutput("rr spacing", 32'(lastAckCycle - prevAck), 4);
         prevAck = lastAckCycle;
      end

      // Reset during WRITE: no ack may follow
      applyStimulus(4'b0100, 32'h00C8_0000);
      step();
      step();
      checkOutput("midrst pre reg_en", 32'(reg_en), 1);
      reset = 1'b1;
      req   = '0;
      step();
      checkOutput("midrst reg_en", 32'(reg_en), 0);
      checkOutput("midrst ack", 32'(ack), 0);
      checkOutput("midrst busy", 32'(busy), 0);
      checkOutput("midrst reg_d", 32'(reg_d), 0);
      checkOutput("midrst rdata", 32'(rdata), 0);
      reset    = 1'b0;
      modelPtr = 0;
      errModel = 1'b0;
      for (int k = 0; k < 5; k++) begin
         checkOutput("midrst no ack", 32'(ack), 0);
         step();
      end
      runTxn(4'b1111, 32'h4433_2211, 0, 1'b0, "midrst ptr");

      // Readback mismatch: register stuck at zero while 0xFF is written
      doReset();
      forceZero = 1'b1;
      runTxn(4'b0001, 32'h0000_00FF, 0, 1'b0, "rb");
      forceZero = 1'b0;
      runTxn(4'b0010, 32'h0000_1200, 1, 1'b0, "rb sticky");
      runIdle("rb idle");
      checkOutput("rb persist", 32'(err), 32'(errModel));
      doReset();

      // Randomized transactions against the model
      for (int it = 0; it < 60; it++) begin
         r         = N'($urandom_range(0, 15));
         wd        = {$urandom};
         forceZero = ($urandom_range(0, 7) == 0);
         w         = modelPick(r, modelPtr);
         if (w < 0) runIdle("rand");
         else runTxn(r, wd, w, ($urandom_range(0, 3) == 0), "rand");
      end
      forceZero = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
